// File: rtl/seq_event_logger_if.sv
// Event-logger port bundle: detector/control inputs and the valid/ready record
// stream with status.
interface seq_event_logger_if #(
  parameter int TS_W  = 16,
  parameter int SEQ_W = 8,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             en;
  logic             det;
  logic             clr;
  logic             ev_ready;
  logic             ev_valid;
  logic [TS_W-1:0]  ev_ts;
  logic [SEQ_W-1:0] ev_seq;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] total_cnt;
  logic             ovf;

  modport master (
    output en, det, clr, ev_ready,
    input  ev_valid, ev_ts, ev_seq, level, total_cnt, ovf
  );

  modport slave (
    input  en, det, clr, ev_ready,
    output ev_valid, ev_ts, ev_seq, level, total_cnt, ovf
  );
endinterface

// File: rtl/seq_event_logger.sv
// Turns rising edges of a sequence-detector output into {seq, ts} records,
// queues them in a small show-ahead FIFO and tracks accepted/dropped events.
module seq_event_logger #(
  parameter int TS_W  = 16,
  parameter int SEQ_W = 8,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_event_logger_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [TS_W-1:0]  ts;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic             det_q;
  logic [TS_W-1:0]  ts_q,    ts_d;
  logic [SEQ_W-1:0] seq_q,   seq_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic [AW-1:0]    wr_q,    wr_d;
  logic [AW-1:0]    rd_q,    rd_d;
  logic [LW-1:0]    level_q, level_d;

  logic evt, full, valid, pop, push, drop;
  rec_t head;

  assign evt   = bus.en & bus.det & ~det_q;
  assign full  = (level_q == LW'(DEPTH));
  assign valid = (level_q != '0);
  assign pop   = valid & bus.ev_ready;
  // A full FIFO still takes the new record when the head leaves this cycle.
  assign push  = evt & (~full | pop);
  assign drop  = evt & full & ~pop;

  always_comb begin
    ts_d    = ts_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (bus.clr) begin
      ts_d    = '0;
      seq_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (bus.en) ts_d = ts_q + TS_W'(1);
      if (push) begin
        wr_d  = wr_q + AW'(1);
        seq_d = seq_q + SEQ_W'(1);
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      if (pop)  rd_d  = rd_q + AW'(1);
      if (drop) ovf_d = 1'b1;
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_q   <= 1'b0;
      ts_q    <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      det_q   <= bus.det;
      ts_q    <= ts_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: reads are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !bus.clr) mem_q[wr_q] <= '{seq: seq_q, ts: ts_q};
  end

  assign head          = mem_q[rd_q];
  assign bus.ev_valid  = valid;
  assign bus.ev_ts     = valid ? head.ts  : '0;
  assign bus.ev_seq    = valid ? head.seq : '0;
  assign bus.level     = level_q;
  assign bus.total_cnt = cnt_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_event_logger.sv
// Bench for seq_event_logger: behavioural scoreboard of expected records plus
// table-driven and hand-written corner sequences.
module tb_seq_event_logger;
  localparam int TS_W  = 4;
  localparam int SEQ_W = 8;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [TS_W-1:0]  ts;
  } rec_t;

  typedef struct {
    logic en, det, rdy, clr;
    int   idle;
    int   lvl;
    logic ovf;
    int   cnt;
  } vec_t;

  logic clk, rst;
  seq_event_logger_if #(.TS_W(TS_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

  seq_event_logger #(.TS_W(TS_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_tot  = 0;

  rec_t             sb[$];
  logic [TS_W-1:0]  ts_m;
  logic [SEQ_W-1:0] seq_m;
  int               cnt_m;
  logic             ovf_m;
  logic             det_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    sb.delete();
    ts_m = '0; seq_m = '0; cnt_m = 0; ovf_m = 1'b0; det_m = 1'b0;
  endtask

  // One clock: drive inputs at the negedge, retire/enqueue expected records,
  // advance the model, then check status at the following negedge.
  task automatic cyc(input logic e, input logic d, input logic r, input logic c);
    logic pop_m, evt_m, full_m;
    rec_t rec;
    bus.en = e; bus.det = d; bus.ev_ready = r; bus.clr = c;
    pop_m  = (sb.size() != 0) && r;
    evt_m  = e && d && !det_m;
    full_m = (sb.size() == DEPTH);
    if (c) begin
      sb.delete();
      ts_m = '0; seq_m = '0; cnt_m = 0; ovf_m = 1'b0;
    end else begin
      if (pop_m) begin
        rec = sb.pop_front();
        chk("head_ts",  32'(bus.ev_ts),  32'(rec.ts));
        chk("head_seq", 32'(bus.ev_seq), 32'(rec.seq));
      end
      if (evt_m && (!full_m || pop_m)) begin
        sb.push_back('{seq: seq_m, ts: ts_m});
        seq_m++;
        if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
      end else if (evt_m) begin
        ovf_m = 1'b1;
      end
      if (e) ts_m++;
    end
    det_m = d;
    @(posedge clk);
    @(negedge clk);
    chk("ev_valid",  32'(bus.ev_valid),  32'(sb.size() != 0));
    chk("level",     32'(bus.level),     32'(sb.size()));
    chk("total_cnt", 32'(bus.total_cnt), 32'(cnt_m));
    chk("ovf",       32'(bus.ovf),       32'(ovf_m));
  endtask

  vec_t tbl[5];

  initial begin
    // Five pulses 4 cycles apart with the consumer stalled: fifth one drops.
    tbl = '{
      '{1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0, 1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 3, 2, 1'b0, 2},
      '{1'b1, 1'b1, 1'b0, 1'b0, 3, 3, 1'b0, 3},
      '{1'b1, 1'b1, 1'b0, 1'b0, 3, 4, 1'b0, 4},
      '{1'b1, 1'b1, 1'b0, 1'b0, 3, 4, 1'b1, 4}
    };
    bus.en = 1'b0; bus.det = 1'b0; bus.clr = 1'b0; bus.ev_ready = 1'b0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    chk("rst_valid", 32'(bus.ev_valid),  0);
    chk("rst_level", 32'(bus.level),     0);
    chk("rst_cnt",   32'(bus.total_cnt), 0);
    chk("rst_ovf",   32'(bus.ovf),       0);
    chk("rst_ts",    32'(bus.ev_ts),     0);
    chk("rst_seq",   32'(bus.ev_seq),    0);
    @(negedge clk);
    rst = 1'b1;

    // Single pulse at ts=5
    repeat (5) cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 0);
    chk("t1_ts",  32'(bus.ev_ts),  5);
    chk("t1_seq", 32'(bus.ev_seq), 0);
    cyc(1, 0, 1, 0);
    chk("t1_level", 32'(bus.level),     0);
    chk("t1_cnt",   32'(bus.total_cnt), 1);

    // Fill past full, then drain in order
    cyc(1, 0, 1, 1);
    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].det, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_level", i), 32'(bus.level),     32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_ovf",   i), 32'(bus.ovf),       32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_cnt",   i), 32'(bus.total_cnt), 32'(tbl[i].cnt));
      repeat (tbl[i].idle) cyc(tbl[i].en, 1'b0, tbl[i].rdy, 1'b0);
    end
    chk("t2_head_seq", 32'(bus.ev_seq), 0);
    repeat (5) cyc(1, 0, 1, 0);
    chk("t2_ovf_sticky", 32'(bus.ovf), 1);

    // Full FIFO with simultaneous pop accepts the push
    cyc(1, 0, 1, 1);
    repeat (4) begin cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); end
    chk("t3_full", 32'(bus.level), 4);
    cyc(1, 1, 1, 0);
    chk("t3_level", 32'(bus.level),     4);
    chk("t3_ovf",   32'(bus.ovf),       0);
    chk("t3_cnt",   32'(bus.total_cnt), 5);
    repeat (5) cyc(1, 0, 1, 0);

    // Timestamp wrap
    cyc(1, 0, 1, 1);
    repeat (15) cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 0);
    chk("t4_ts15", 32'(bus.ev_ts), 15);
    repeat (3) cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 0);
    chk("t4_ts3", 32'(bus.ev_ts), 3);
    cyc(1, 0, 1, 0);

    // Held det gives one record; en=0 blocks events and freezes ts
    repeat (3) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t5_held_level", 32'(bus.level), 1);
    repeat (2) cyc(1, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t5_en0_level", 32'(bus.level), 0);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);

    // Async reset mid-operation with three records stored
    repeat (3) begin cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); end
    chk("t6_pre_level", 32'(bus.level), 3);
    bus.en = 1'b0; bus.det = 1'b0; bus.ev_ready = 1'b0; bus.clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.ev_valid),  0);
    chk("t6_rst_level", 32'(bus.level),     0);
    chk("t6_rst_cnt",   32'(bus.total_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // clr beats a same-cycle event; det still high afterwards must not retrigger
    cyc(1, 1, 1, 1);
    chk("t6_clr_level", 32'(bus.level),     0);
    chk("t6_clr_cnt",   32'(bus.total_cnt), 0);
    cyc(1, 1, 1, 0);
    chk("t6_noretrig", 32'(bus.level), 0);
    cyc(1, 0, 1, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
